sap_mem_arbiter: RTL and testbench
==================================

Name: sap_mem_arbiter

Overview:
- Sequences and shares the 16x8 program/data SRAM between two requesters: the CPU fetch/operand path (read-only) and a host loader port (read/write).
- Sits between the CPU's MAR/bus side and a synchronous single-port RAM. Lets programs be loaded or inspected without editing the RAM contents at build time.
- Provides round-robin arbitration, a CPU hold (host_lock) and a request/grant/valid handshake on both sides.

Parameters:
ADDR_W, 4, address width (16 locations)
DATA_W, 8, data width
WPROT_TOP, 5, highest protected address (program region 0..WPROT_TOP); used only with optional feature

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
cpu_req  in  1  CPU read request; held until cpu_gnt
cpu_addr  in  ADDR_W  CPU read address
cpu_gnt  out  1  one-cycle pulse: CPU request accepted
cpu_rvalid  out  1  one-cycle pulse: cpu_rdata valid
cpu_rdata  out  DATA_W  read data; holds last value
cpu_stall  out  1  cpu_req pending and not yet granted
host_req  in  1  host request; held until host_gnt
host_we  in  1  1 = write, 0 = read
host_addr  in  ADDR_W  host address
host_wdata  in  DATA_W  host write data
host_lock  in  1  level: CPU ineligible for grant while high
host_gnt  out  1  one-cycle pulse: host request accepted
host_done  out  1  one-cycle pulse: host read data valid or write complete
host_rdata  out  DATA_W  read data; holds last value
host_err  out  1  one-cycle pulse with host_done when a write was dropped (optional feature only; else tied 0)
mem_en  out  1  RAM access enable
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM read data, valid the cycle after mem_en (1-cycle read latency)

Behaviour:
- States: IDLE, ACCESS, RESP. Reset enters IDLE.
- Reset values: all pulses 0, cpu_rdata = host_rdata = 0, mem_* = 0, last_winner = CPU.
- Reset mid-transaction aborts it. No mem_we is issued after rst asserts, and no gnt/done follows.
- Eligibility: cpu_req && !host_lock for the CPU; host_req for the host.
- Arbitration runs at the clock edge in IDLE or RESP.
  - If only one requester is eligible, it wins.
  - If both are eligible, the winner is the one that is not last_winner. After reset, the host wins the first tie.
- On a win, the winner's address, we and wdata are latched, last_winner is updated and the state goes to ACCESS.
  - A CPU win forces we = 0.
- ACCESS, one cycle:
  - mem_en = 1; mem_we, mem_addr and mem_wdata are driven from the latched values.
  - The winner's gnt pulses high. The requester may drop req or change its inputs from the next cycle.
  - Next state is RESP.
- RESP, one cycle:
  - For a read, mem_rdata is captured into the winner's rdata register and cpu_rvalid or host_done pulses in the same cycle, with the data visible on that cycle.
  - For a host write, host_done pulses.
  - Arbitration is evaluated again: a pending eligible request goes to ACCESS, otherwise the state goes to IDLE.
- Latency and throughput:
  - From IDLE, req seen at edge k gives gnt in cycle k+1 and rvalid/done in cycle k+2.
  - Back-to-back sustained throughput is one transaction per 2 cycles.
- cpu_stall is combinational: cpu_req && !(cpu_gnt). It is high throughout host_lock.
- host_lock asserted while a CPU transaction is in ACCESS/RESP lets that transaction complete. No new CPU grant is issued until host_lock deasserts.
- A requester that drops req before its gnt is not served. It is not latched until the win edge.
- Outside ACCESS: mem_en = mem_we = 0, and mem_addr/mem_wdata hold their last values.

Optional Feature:
- Macro SAP_MEM_WPROT_EN.
- Defined: a host write with addr <= WPROT_TOP while host_lock = 0 is dropped. ACCESS then drives mem_en = 1 and mem_we = 0, and RESP pulses host_done and host_err together. With host_lock = 1, all writes proceed.
- Undefined: no protection and host_err tied 0.

Test Plan:
- Reset, then CPU read addr 9 with RAM[9] = 0x01 -> cpu_gnt at cycle +1; cpu_rvalid and cpu_rdata = 0x01 at cycle +2; cpu_stall high for exactly 1 cycle.
- Host write 0x5A to addr 12, then host read addr 12 -> host_done after each; read returns host_rdata = 0x5A; mem_we high only in the write's ACCESS cycle.
- cpu_req and host_req held high continuously -> grants alternate host, CPU, host, CPU; each grant every 2 cycles; host first after reset.
- host_lock = 1 with cpu_req high during 4 host writes -> no cpu_gnt, cpu_stall = 1 throughout; after lock drops, cpu_gnt within 2 cycles.
- rst asserted during ACCESS of a host write -> mem_we falls immediately, no host_done, state IDLE, all outputs at reset values.
- SAP_MEM_WPROT_EN defined: host write 0xFF to addr 3, host_lock = 0 -> host_err and host_done pulse, mem_we never 1, RAM[3] unchanged; repeat with host_lock = 1 -> RAM[3] = 0xFF, host_err = 0.

Source files
------------

// File: rtl/sap_mem_arbiter.sv
// Shares the 16x8 SAP program/data RAM between the CPU read path and a host loader port.
// Latency: gnt the cycle after a winning req is seen, rvalid/done one cycle later; sustained one access per 2 cycles.
// Backpressure: requests hold until gnt; host_lock keeps the CPU from winning. `SAP_MEM_WPROT_EN drops low-region host writes.
module sap_mem_arbiter #(
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 8,
    parameter int WPROT_TOP = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    input  logic              host_lock,
    output logic              host_gnt,
    output logic              host_done,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state, state_nxt;
    logic              cpu_elig, host_elig;
    logic              win, win_host;
    logic              drop_now;
    logic              last_host;
    logic              own_host;
    logic              lat_wr;
    logic              lat_drop;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] cpu_rdata_q, host_rdata_q;
    logic              in_acc, in_resp;

    assign cpu_elig  = cpu_req && !host_lock;
    assign host_elig = host_req;

`ifdef SAP_MEM_WPROT_EN
    localparam logic [ADDR_W-1:0] WPROT_ADDR = WPROT_TOP[ADDR_W-1:0];
    assign drop_now = host_we && (host_addr <= WPROT_ADDR) && !host_lock;
    assign host_err = host_done && lat_drop;
`else
    localparam int wprot_top_unused = WPROT_TOP;
    assign drop_now = 1'b0;
    assign host_err = 1'b0;
`endif

    // On a tie the requester that did not win last time takes the slot.
    always_comb begin
        state_nxt = state;
        win       = 1'b0;
        win_host  = 1'b0;
        if (state == ACCESS) begin
            state_nxt = RESP;
        end else begin
            win       = cpu_elig || host_elig;
            win_host  = host_elig && (!cpu_elig || !last_host);
            state_nxt = win ? ACCESS : IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_host <= 1'b0;
            own_host  <= 1'b0;
            lat_wr    <= 1'b0;
            lat_drop  <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (win) begin
            last_host <= win_host;
            own_host  <= win_host;
            lat_wr    <= win_host && host_we;
            lat_drop  <= win_host && drop_now;
            lat_addr  <= win_host ? host_addr : cpu_addr;
            if (win_host) begin
                lat_wdata <= host_wdata;
            end
        end
    end

    assign in_acc  = (state == ACCESS);
    assign in_resp = (state == RESP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_rdata_q  <= '0;
            host_rdata_q <= '0;
        end else begin
            if (cpu_rvalid) begin
                cpu_rdata_q <= mem_rdata;
            end
            if (host_done && !lat_wr) begin
                host_rdata_q <= mem_rdata;
            end
        end
    end

    assign cpu_gnt    = in_acc && !own_host;
    assign host_gnt   = in_acc && own_host;
    assign cpu_rvalid = in_resp && !own_host;
    assign host_done  = in_resp && own_host;
    assign cpu_stall  = cpu_req && !cpu_gnt;

    // Read data is forwarded straight from the RAM in its valid cycle, then held.
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_rdata_q;
    assign host_rdata = (host_done && !lat_wr) ? mem_rdata : host_rdata_q;

    assign mem_en    = in_acc;
    assign mem_we    = in_acc && lat_wr && !lat_drop;
    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;

endmodule

// File: tb/tb_sap_mem_arbiter.sv
// Bench for sap_mem_arbiter: directed scenarios plus random traffic against a transaction-level scoreboard.
// Drives inputs 1ns after posedge, samples outputs at negedge; includes a 16x8 synchronous RAM.
// Every wait on the DUT is bounded by a cycle budget.
module tb_sap_mem_arbiter;
    localparam int AW  = 4;
    localparam int DW  = 8;
    localparam int WPT = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req, cpu_gnt, cpu_rvalid, cpu_stall;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_rdata;
    logic          host_req, host_we, host_lock, host_gnt, host_done, host_err;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata, host_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    sap_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WPROT_TOP(WPT)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_gnt(cpu_gnt),
        .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_lock(host_lock), .host_gnt(host_gnt),
        .host_done(host_done), .host_rdata(host_rdata), .host_err(host_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    function automatic logic [7:0] init_val(input int i);
        return 8'(i * 29) ^ 8'h04;
    endfunction

    logic          ram_load;
    logic [DW-1:0] ram [16];
    always @(posedge clk) begin
        if (ram_load) begin
            for (int i = 0; i < 16; i++) ram[i] <= init_val(i);
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            mem_rdata <= ram[mem_addr];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Scoreboard: one outstanding transaction, decided at a free edge, gnt next cycle, response the cycle after.
    logic [DW-1:0] shadow [16];
    int            free_cyc, t_gc;
    bit            t_act, t_host, t_we, t_drop, last_host;
    logic [AW-1:0] t_addr, exp_maddr;
    logic [DW-1:0] t_data, exp_crd, exp_hrd;
    bit            m_cg, m_hg, o_cg;
    int            stall_cnt, we_cnt, cgnt_cnt, err_cnt, rv_cyc;
    bit            gq_who [$];
    int            gq_cyc [$];

    task automatic model_init();
        t_act = 0; last_host = 0; free_cyc = cyc;
        exp_crd = '0; exp_hrd = '0; exp_maddr = '0;
        m_cg = 0; m_hg = 0;
    endtask

    task automatic model_eval();
        bit e_cg, e_hg, e_crv, e_hd, e_men, e_mwe, ce, he, hw;
        e_cg  = t_act && cyc == t_gc && !t_host;
        e_hg  = t_act && cyc == t_gc && t_host;
        e_crv = t_act && cyc == t_gc + 1 && !t_host;
        e_hd  = t_act && cyc == t_gc + 1 && t_host;
        e_men = t_act && cyc == t_gc;
        e_mwe = e_men && t_we && !t_drop;
        if (e_men) exp_maddr = t_addr;
        if (e_crv) exp_crd = t_data;
        if (e_hd && !t_we) exp_hrd = t_data;
        chk("cpu_gnt", cpu_gnt, e_cg);
        chk("host_gnt", host_gnt, e_hg);
        chk("cpu_rvalid", cpu_rvalid, e_crv);
        chk("host_done", host_done, e_hd);
        chk("host_err", host_err, e_hd && t_drop);
        chk("mem_en", mem_en, e_men);
        chk("mem_we", mem_we, e_mwe);
        chk("mem_addr", mem_addr, exp_maddr);
        chk("cpu_rdata", cpu_rdata, exp_crd);
        chk("host_rdata", host_rdata, exp_hrd);
        chk("cpu_stall", cpu_stall, cpu_req && !e_cg);
        if (e_mwe) chk("mem_wdata", mem_wdata, t_data);
        if (e_hd && t_we && !t_drop) shadow[t_addr] = t_data;
        m_cg = e_cg; m_hg = e_hg; o_cg = cpu_gnt;
        stall_cnt += int'(cpu_stall);
        we_cnt    += int'(mem_we);
        cgnt_cnt  += int'(cpu_gnt);
        err_cnt   += int'(host_err);
        if (cpu_rvalid) rv_cyc = cyc;
        if (cpu_gnt || host_gnt) begin
            gq_who.push_back(host_gnt);
            gq_cyc.push_back(cyc);
        end
        if (cyc >= free_cyc) begin
            ce = cpu_req && !host_lock;
            he = host_req;
            if (ce || he) begin
                hw = he && (!ce || !last_host);
                t_act = 1; t_host = hw; t_gc = cyc + 1;
                free_cyc = cyc + 2; last_host = hw;
                if (hw) begin
                    t_we = host_we; t_addr = host_addr; t_drop = 0;
`ifdef SAP_MEM_WPROT_EN
                    t_drop = host_we && (host_addr <= 4'(WPT)) && !host_lock;
`endif
                    t_data = host_we ? host_wdata : shadow[host_addr];
                end else begin
                    t_we = 0; t_addr = cpu_addr; t_drop = 0;
                    t_data = shadow[cpu_addr];
                end
            end else begin
                free_cyc = cyc + 1;
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        if (!rst) model_eval();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #1;
        chk("rst_cpu_gnt", cpu_gnt, 0);
        chk("rst_host_gnt", host_gnt, 0);
        chk("rst_cpu_rvalid", cpu_rvalid, 0);
        chk("rst_host_done", host_done, 0);
        chk("rst_host_err", host_err, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_host_rdata", host_rdata, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_init();
    endtask

    task automatic cpu_read(input logic [AW-1:0] a);
        bit got = 0;
        cpu_req = 1; cpu_addr = a;
        for (int n = 0; n < 40 && !got; n++) begin
            cycle();
            got = m_cg;
        end
        if (!got) chk("cpu_gnt_wait", 0, 1);
        cpu_req = 0;
        cycle();
    endtask

    task automatic host_op(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit got = 0;
        host_req = 1; host_we = we; host_addr = a; host_wdata = d;
        for (int n = 0; n < 40 && !got; n++) begin
            cycle();
            got = m_hg;
        end
        if (!got) chk("host_gnt_wait", 0, 1);
        host_req = 0;
        cycle();
    endtask

    task automatic rand_step();
        if (cpu_req) begin
            if (m_cg || $urandom_range(31) == 0) cpu_req = 0;
        end else if ($urandom_range(2) == 0) begin
            cpu_req = 1; cpu_addr = 4'($urandom);
        end
        if (host_req) begin
            if (m_hg || $urandom_range(31) == 0) host_req = 0;
        end else if ($urandom_range(2) == 0) begin
            host_req = 1; host_we = 1'($urandom); host_addr = 4'($urandom); host_wdata = 8'($urandom);
        end
        if ($urandom_range(24) == 0) host_lock = !host_lock;
    endtask

    initial begin
        int req_cyc, c0;
        bit got;
        rst = 0; ram_load = 1;
        cpu_req = 0; cpu_addr = '0;
        host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0; host_lock = 0;
        for (int i = 0; i < 16; i++) shadow[i] = init_val(i);
        model_init();
        @(posedge clk);
        #1;
        ram_load = 0;
        apply_reset();

        // CPU single read of address 9
        stall_cnt = 0; rv_cyc = -1; req_cyc = cyc;
        cpu_read(4'd9);
        chk("cpu9_rdata", cpu_rdata, 8'h01);
        chk("cpu9_stall_cycles", stall_cnt, 1);
        chk("cpu9_rvalid_latency", rv_cyc - req_cyc, 2);

        // Host write then read back
        we_cnt = 0;
        host_op(1, 4'd12, 8'h5A);
        host_op(0, 4'd12, 8'h00);
        chk("host12_rdata", host_rdata, 8'h5A);
        chk("host12_we_cycles", we_cnt, 1);

        // Both requesting continuously from reset: host first, then alternate every 2 cycles
        apply_reset();
        gq_who.delete(); gq_cyc.delete();
        cpu_req = 1; cpu_addr = 4'd5; host_req = 1; host_we = 0; host_addr = 4'd6;
        repeat (12) cycle();
        cpu_req = 0; host_req = 0;
        repeat (3) cycle();
        chk("alt_count", gq_who.size(), 6);
        for (int i = 0; i < 6 && i < gq_who.size(); i++) begin
            chk("alt_winner", gq_who[i], (i % 2 == 0));
            if (i > 0) chk("alt_spacing", gq_cyc[i] - gq_cyc[i-1], 2);
        end

        // host_lock blocks the CPU during four host writes
        host_lock = 1; cpu_req = 1; cpu_addr = 4'd2;
        cgnt_cnt = 0; stall_cnt = 0; c0 = cyc;
        host_op(1, 4'd13, 8'h31);
        host_op(1, 4'd14, 8'h42);
        host_op(1, 4'd15, 8'h53);
        host_op(1, 4'd11, 8'h64);
        chk("lock_no_cpu_gnt", cgnt_cnt, 0);
        chk("lock_stall_all", stall_cnt, cyc - c0);
        host_lock = 0;
        got = 0;
        for (int n = 0; n < 2 && !got; n++) begin
            cycle();
            got = o_cg;
        end
        chk("unlock_cpu_gnt", got, 1);
        cpu_req = 0;
        repeat (2) cycle();

        // Reset during the ACCESS cycle of a host write
        host_req = 1; host_we = 1; host_addr = 4'd7; host_wdata = 8'hC3;
        got = 0;
        for (int n = 0; n < 10 && !got; n++) begin
            cycle();
            got = t_act && t_host && (t_gc == cyc);
        end
        chk("abort_reached_access", got, 1);
        #2;
        chk("abort_pre_mem_we", mem_we, 1);
        host_req = 0;
        apply_reset();
        repeat (2) cycle();
        host_op(0, 4'd7, 8'h00);
        chk("abort_ram_kept", host_rdata, init_val(7));

`ifdef SAP_MEM_WPROT_EN
        we_cnt = 0; err_cnt = 0; host_lock = 0;
        host_op(1, 4'd3, 8'hFF);
        chk("wprot_err_count", err_cnt, 1);
        chk("wprot_no_we", we_cnt, 0);
        host_op(0, 4'd3, 8'h00);
        chk("wprot_ram_kept", host_rdata, init_val(3));
        err_cnt = 0; host_lock = 1;
        host_op(1, 4'd3, 8'hFF);
        host_lock = 0;
        host_op(0, 4'd3, 8'h00);
        chk("wprot_lock_ram", host_rdata, 8'hFF);
        chk("wprot_lock_no_err", err_cnt, 0);
`endif

        // Random mixed traffic against the scoreboard
        for (int n = 0; n < 1500; n++) begin
            rand_step();
            cycle();
        end
        cpu_req = 0; host_req = 0; host_lock = 0;
        repeat (4) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
